// File: rtl/sw_sampler_pkg.sv
// Shared types and constants for the switch operand sampler.
package sw_sampler_pkg;

    typedef logic [1:0] operand_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int NUM_SW              = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;  // 10 ms at 25 MHz
    localparam int SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/switch_debounce.sv
// Per-switch synchroniser followed by a hold-time debouncer. A new level is
// accepted only after the synchronised input has disagreed with the current
// debounced level for DEBOUNCE_CYCLES consecutive clocks; any bounce back to
// the old level restarts the count.
module switch_debounce
    import sw_sampler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_Level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   synced;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], i_Raw};
    assign synced  = sync_q[SYNC_STAGES-1];
    assign o_Level = level_q;

    // Next-state for the hold counter and accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TERM) begin
            level_d = synced;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser chain, counter and debounced level registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/switch_operand_sampler.sv
// Debounces four board switches, packs them into operands A={sw2,sw1} and
// B={sw4,sw3}, and offers each new stable pair over a valid/ready handshake.
// Define SW_SAMPLER_XFER_CNT_EN to add the 8-bit accepted-transfer counter
// output o_Xfer_Cnt.
module switch_operand_sampler
    import sw_sampler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       sw1,
    input  logic       sw2,
    input  logic       sw3,
    input  logic       sw4,
    output operand_t   o_Op_A,
    output operand_t   o_Op_B,
    output logic       o_Valid,
    input  logic       i_Ready
`ifdef SW_SAMPLER_XFER_CNT_EN
    ,
    output logic [7:0] o_Xfer_Cnt
`endif
);

    logic [NUM_SW-1:0] raw;
    logic [NUM_SW-1:0] level;
    state_t            state_q;
    operand_t          op_a_q;
    operand_t          op_b_q;
    logic              valid_q;

    assign raw = {sw4, sw3, sw2, sw1};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_debounce (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Raw   (raw[g]),
            .o_Level (level[g])
        );
    end

    assign o_Op_A  = op_a_q;
    assign o_Op_B  = op_b_q;
    assign o_Valid = valid_q;

    // Offer FSM: load a changed pair in IDLE, hold it untouched until accepted.
    // Changes arriving while PEND are picked up by the IDLE compare afterwards,
    // so intermediate values coalesce into the latest pair.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (level != {op_b_q, op_a_q}) begin
                        op_a_q  <= level[1:0];
                        op_b_q  <= level[3:2];
                        valid_q <= 1'b1;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (i_Ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SW_SAMPLER_XFER_CNT_EN
    logic [7:0] xfer_cnt_q;

    assign o_Xfer_Cnt = xfer_cnt_q;

    // Count accepted transfers, wrapping naturally at 8 bits.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            xfer_cnt_q <= '0;
        end else if (valid_q && i_Ready) begin
            xfer_cnt_q <= xfer_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_operand_sampler.sv
// Bench for switch_operand_sampler with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Directed scenarios plus random switch/ready traffic, checked every clock
// against a behavioural model of the switch-to-pair rules.
module tb_switch_operand_sampler;

    localparam int DB = 4;
    localparam int SS = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] op_a, op_b;
    logic       valid;
`ifdef SW_SAMPLER_XFER_CNT_EN
    logic [7:0] xfer_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit seen_valid;

    always #5 clk = ~clk;

    switch_operand_sampler #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .sw1     (sw1),
        .sw2     (sw2),
        .sw3     (sw3),
        .sw4     (sw4),
        .o_Op_A  (op_a),
        .o_Op_B  (op_b),
        .o_Valid (valid),
        .i_Ready (ready)
`ifdef SW_SAMPLER_XFER_CNT_EN
        ,
        .o_Xfer_Cnt (xfer_cnt)
`endif
    );

    // Reference model: raw pin history, synchronised-level window, accepted
    // levels, presented pair, valid flag and transfer count.
    logic [3:0] raw_h [SS];
    logic [3:0] syn_h [DB];
    logic [3:0] deb_m;
    logic [3:0] pres_m;
    logic       valid_m;
    int         xfer_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < SS; i++) raw_h[i] = '0;
        for (int i = 0; i < DB; i++) syn_h[i] = '0;
        deb_m   = '0;
        pres_m  = '0;
        valid_m = 1'b0;
        xfer_m  = 0;
    endfunction

    // One rising edge of the model, using the inputs present before the edge.
    function automatic void model_edge();
        logic [3:0] synced;
        bit         all_differ;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!valid_m) begin
            if (deb_m != pres_m) begin
                pres_m  = deb_m;
                valid_m = 1'b1;
            end
        end else if (ready) begin
            valid_m = 1'b0;
            xfer_m  = (xfer_m + 1) % 256;
        end
        synced = raw_h[0];
        for (int i = 0; i < SS - 1; i++) raw_h[i] = raw_h[i+1];
        raw_h[SS-1] = {sw4, sw3, sw2, sw1};
        for (int i = 0; i < DB - 1; i++) syn_h[i] = syn_h[i+1];
        syn_h[DB-1] = synced;
        // A switch flips once its last DB synchronised samples all disagree.
        for (int s = 0; s < 4; s++) begin
            all_differ = 1'b1;
            for (int j = 0; j < DB; j++)
                if (syn_h[j][s] == deb_m[s]) all_differ = 1'b0;
            if (all_differ) deb_m[s] = synced[s];
        end
    endfunction

    task automatic compare_all();
        chk("valid", 32'(valid), 32'(valid_m));
        chk("op_a", 32'(op_a), 32'(pres_m[1:0]));
        chk("op_b", 32'(op_b), 32'(pres_m[3:2]));
`ifdef SW_SAMPLER_XFER_CNT_EN
        chk("xfer_cnt", 32'(xfer_cnt), 32'(xfer_m));
`endif
        if (valid === 1'b1) seen_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic flip_sw(input int k);
        case (k)
            0:       sw1 = ~sw1;
            1:       sw2 = ~sw2;
            2:       sw3 = ~sw3;
            default: sw4 = ~sw4;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        steps(3);
        rst_n = 1'b1;

        // Reset idle: all switches off, ready high, nothing offered.
        ready = 1'b1;
        seen_valid = 1'b0;
        steps(50);
        chk("t1_never_valid", 32'(seen_valid), 32'd0);
        chk("t1_op_a", 32'(op_a), 32'd0);
        chk("t1_op_b", 32'(op_b), 32'd0);

        // Clean sw1/sw4 press, consumer stalls, then accepts one clock.
        ready = 1'b0;
        sw1 = 1'b1;
        sw4 = 1'b1;
        steps(6);
        chk("t2_not_yet", 32'(valid), 32'd0);
        step();
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_op_a", 32'(op_a), 32'd1);
        chk("t2_op_b", 32'(op_b), 32'd2);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t2_hold_valid", 32'(valid), 32'd1);
            chk("t2_hold_b", 32'(op_b), 32'd2);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t2_accepted", 32'(valid), 32'd0);

        // Back to all off and drain that offer.
        sw1 = 1'b0;
        sw4 = 1'b0;
        ready = 1'b1;
        steps(12);

        // Bouncing sw2 never settles, so nothing is offered.
        ready = 1'b0;
        seen_valid = 1'b0;
        sw2 = 1'b1; steps(2);
        sw2 = 1'b0; steps(2);
        sw2 = 1'b1; steps(2);
        sw2 = 1'b0; steps(12);
        chk("t3_bounce_ignored", 32'(seen_valid), 32'd0);
        sw2 = 1'b1; step();
        sw2 = 1'b0; step();
        sw2 = 1'b1; steps(8);
        chk("t3_valid", 32'(valid), 32'd1);
        chk("t3_op_a", 32'(op_a), 32'd2);
        chk("t3_op_b", 32'(op_b), 32'd0);
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Change during PEND: latest pair re-offered after the accept.
        sw3 = 1'b1;
        steps(8);
        chk("t4_pend_b", 32'(op_b), 32'd1);
        sw4 = 1'b1;
        steps(10);
        chk("t4_held_valid", 32'(valid), 32'd1);
        chk("t4_held_b", 32'(op_b), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t4_accept", 32'(valid), 32'd0);
        step();
        chk("t4_reoffer", 32'(valid), 32'd1);
        chk("t4_latest_b", 32'(op_b), 32'd3);

        // Asynchronous reset while an offer is outstanding.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_valid", 32'(valid), 32'd0);
        chk("t5_op_a", 32'(op_a), 32'd0);
        chk("t5_op_b", 32'(op_b), 32'd0);
        steps(3);
        rst_n = 1'b1;
        ready = 1'b1;
        steps(12);
        sw2 = 1'b0;
        sw3 = 1'b0;
        sw4 = 1'b0;
        steps(12);

        // Random pin activity and random back-pressure.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) flip_sw(int'($urandom_range(0, 3)));
            ready = ($urandom_range(0, 2) != 0);
            step();
        end

`ifdef SW_SAMPLER_XFER_CNT_EN
        // 257 accepted transfers wrap the counter to 1.
        sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
        ready = 1'b1;
        steps(12);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            sw1 = ~sw1;
            steps(10);
        end
        chk("t6_wrapped", 32'(xfer_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
